// File: rtl/alu_pkg.sv
// Shared function-code constants and the fnct_sel decoder for the ALU result selector.
// The decoder yields a one-hot-free selection code; SEL_NONE marks every undecoded code.
package alu_pkg;

    localparam logic [2:0] FG_CHK   = 3'b000;
    localparam logic [2:0] FG_ARITH = 3'b001;
    localparam logic [2:0] FG_LOGIC = 3'b010;
    localparam logic [2:0] FG_RSVD  = 3'b100;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_AND = 6'h00;
    localparam logic [5:0] OP_OR  = 6'h01;
    localparam logic [5:0] OP_XOR = 6'h02;
    localparam logic [5:0] OP_SFL = 6'h03;
    localparam logic [5:0] OP_SFR = 6'h04;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CHK,
        SEL_ADD,
        SEL_SUB,
        SEL_AND,
        SEL_OR,
        SEL_XOR,
        SEL_SFL,
        SEL_SFR
    } res_sel_e;

    function automatic res_sel_e decode_fnct(input logic [8:0] fnct);
        logic [2:0] grp;
        logic [5:0] op;
        res_sel_e   sel;
        grp = fnct[8:6];
        op  = fnct[5:0];
        sel = SEL_NONE;
        case (grp)
            FG_CHK: sel = SEL_CHK;
            FG_ARITH: begin
                case (op)
                    OP_ADD:  sel = SEL_ADD;
                    OP_SUB:  sel = SEL_SUB;
                    default: sel = SEL_NONE;
                endcase
            end
            FG_LOGIC: begin
                case (op)
                    OP_AND:  sel = SEL_AND;
                    OP_OR:   sel = SEL_OR;
                    OP_XOR:  sel = SEL_XOR;
                    OP_SFL:  sel = SEL_SFL;
                    OP_SFR:  sel = SEL_SFR;
                    default: sel = SEL_NONE;
                endcase
            end
            FG_RSVD: sel = SEL_NONE;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: output register O backed by skid register S.
// in_ready depends only on S occupancy, so there is no combinational out_ready -> in_ready path.
module alu_skid_buf #(
    parameter int PAYLOAD_W = 34
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 o_valid_q, o_valid_d;
    logic [PAYLOAD_W-1:0] o_data_q,  o_data_d;
    logic                 s_valid_q, s_valid_d;
    logic [PAYLOAD_W-1:0] s_data_q,  s_data_d;
    logic                 accept;
    logic                 xfer;

    assign in_ready    = ~s_valid_q;
    assign accept      = in_valid & ~s_valid_q;
    assign xfer        = o_valid_q & out_ready;
    assign out_valid   = o_valid_q;
    assign out_payload = o_data_q;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (s_valid_q) begin
            // Skid is occupied: upstream is stalled, only draining S into O is possible.
            if (xfer) begin
                o_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!o_valid_q || xfer) begin
                o_valid_d = 1'b1;
                o_data_d  = in_payload;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = in_payload;
            end
        end else if (xfer) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/alu_result_sel.sv
// ALU result selector: decodes fnct_sel, picks a functional-unit result and queues it with
// zero/illegal flags through a skid buffer; counts accepted illegal codes with saturation.
module alu_result_sel
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        fnct_sel,
    input  logic [DATA_W-1:0] add_out,
    input  logic [DATA_W-1:0] sub_out,
    input  logic [DATA_W-1:0] and_out,
    input  logic [DATA_W-1:0] or_out,
    input  logic [DATA_W-1:0] xor_out,
    input  logic [DATA_W-1:0] sfl_out,
    input  logic [DATA_W-1:0] sfr_out,
    input  logic [DATA_W-1:0] chk_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_illegal,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam int               PAYLOAD_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    res_sel_e             sel;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_illegal;
    logic                 sel_zero;
    logic                 accept;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign sel = decode_fnct(fnct_sel);

    always_comb begin
        sel_data = '0;
        case (sel)
            SEL_CHK: sel_data = chk_out;
            SEL_ADD: sel_data = add_out;
            SEL_SUB: sel_data = sub_out;
            SEL_AND: sel_data = and_out;
            SEL_OR:  sel_data = or_out;
            SEL_XOR: sel_data = xor_out;
            SEL_SFL: sel_data = sfl_out;
            SEL_SFR: sel_data = sfr_out;
            default: sel_data = '0;
        endcase
    end

    // Flags travel with the entry so they stay aligned with out_data through any stall.
    assign sel_illegal = (sel == SEL_NONE);
    assign sel_zero    = ~|sel_data;
    assign in_payload  = {sel_illegal, sel_zero, sel_data};
    assign accept      = in_valid & in_ready;

    alu_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst_b       (rst_b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload)
    );

    assign out_illegal = out_payload[PAYLOAD_W-1];
    assign out_zero    = out_payload[PAYLOAD_W-2];
    assign out_data    = out_payload[DATA_W-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && sel_illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;

endmodule
